// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller:
// segment encodings, digit decode table and scan state encoding.
package seg_scan_ctrl_pkg;

    // Active-low segment bus: bit7 = a ... bit1 = g, bit0 = dp.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF7  = 7'h7F;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_GUARD,
        ST_DRIVE
    } scan_state_t;

    // Segments a..g for one digit value; 10-15 are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001101;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_OFF7;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Slot timer: counts 0..SCAN_DIV-1 while run is high.
// Ports: clk, rst (sync, high), clr (sync clear), run,
//        guard_end (last guard clock), slot_end (last slot clock).
module seg_slot_timer #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic guard_end,
    output logic slot_end
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;

    assign guard_end = run && (cnt == CW'(GUARD_CYC - 1));
    assign slot_end  = run && (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            if (slot_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digits.
// Ports: clk, rst (sync, high), disp_en, lz_en; write port wr_en/
//        wr_addr/wr_data/wr_dp/wr_ready; commit_req/commit_ack;
//        frame_done; seg_data and dig_sel (both active-low).
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD_CYC  = 500,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_en,
    input  logic                  lz_en,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    output logic                  wr_ready,
    input  logic                  commit_req,
    output logic                  commit_ack,
    output logic                  frame_done,
    output logic [7:0]            seg_data,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    logic [3:0] shd_val [NUM_DIGITS];
    logic       shd_dp  [NUM_DIGITS];
    logic [3:0] act_val [NUM_DIGITS];
    logic       act_dp  [NUM_DIGITS];

    logic pending;
    scan_state_t state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic guard_end, slot_end;
    logic wrap, copy;
    logic [NUM_DIGITS-1:0] blank;
    logic [7:0] seg_n;
    logic [NUM_DIGITS-1:0] sel_n;

    seg_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD_CYC (GUARD_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (!disp_en || state == ST_OFF),
        .run       (state != ST_OFF),
        .guard_end (guard_end),
        .slot_end  (slot_end)
    );

    assign wr_ready = !pending;

    // Frame boundary: last clock of the last digit's drive slot.
    assign wrap = !rst && disp_en && state == ST_DRIVE && slot_end
               && idx == AW'(NUM_DIGITS - 1);

    // A pending commit lands on a frame boundary, or at once when dark.
    assign copy = !rst && pending && (state == ST_OFF || wrap);

    assign frame_done = wrap;
    assign commit_ack = copy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shd_val[i] <= 4'hF;
                shd_dp[i]  <= 1'b0;
                act_val[i] <= 4'hF;
                act_dp[i]  <= 1'b0;
            end
            pending <= 1'b0;
        end else begin
            if (wr_en && wr_ready) begin
                shd_val[wr_addr] <= wr_data;
                shd_dp[wr_addr]  <= wr_dp;
            end
            if (copy) begin
                act_val <= shd_val;
                act_dp  <= shd_dp;
                pending <= 1'b0;
            end else if (commit_req) begin
                pending <= 1'b1;
            end
        end
    end

    // Leading zeros: scan from the top, blanking zeros until a
    // digit 1-9 is seen. Blank codes 10-15 do not stop the run.
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i > 0 && lz_en && lead && act_val[i] == 4'd0) begin
                blank[i] = 1'b1;
            end
            if (act_val[i] >= 4'd1 && act_val[i] <= 4'd9) begin
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            idx      <= '0;
            seg_data <= SEG_BLANK;
            dig_sel  <= '1;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            seg_data <= seg_n;
            dig_sel  <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            ST_OFF: begin
                state_n = ST_GUARD;
                idx_n   = '0;
            end
            ST_GUARD: begin
                if (guard_end) begin
                    state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (slot_end) begin
                    state_n = ST_GUARD;
                    if (idx == AW'(NUM_DIGITS - 1)) begin
                        idx_n = '0;
                    end else begin
                        idx_n = idx + AW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_OFF;
                idx_n   = '0;
            end
        endcase
        if (!disp_en) begin
            state_n = ST_OFF;
            idx_n   = '0;
        end
    end

    // Outputs are decoded from the next state so they register
    // on the same edge as the state itself.
    always_comb begin
        seg_n = SEG_BLANK;
        sel_n = '1;
        if (state_n == ST_DRIVE) begin
            sel_n = ~(NUM_DIGITS'(1) << idx_n);
            seg_n = {blank[idx_n] ? SEG_OFF7 : seg_decode(act_val[idx_n]),
                     ~act_dp[idx_n]};
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-clock slots,
// 2-clock guard). k counts clocks since the display was enabled.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       disp_en = 1'b0;
    logic       lz_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic       wr_ready;
    logic       commit_req = 1'b0;
    logic       commit_ack;
    logic       frame_done;
    logic [7:0] seg_data;
    logic [3:0] dig_sel;

    int total = 0;
    int bad = 0;
    int k = 0;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    int   ack_q[$];

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .GUARD_CYC  (2),
        .AW         (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_en    (disp_en),
        .lz_en      (lz_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_ready   (wr_ready),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .frame_done (frame_done),
        .seg_data   (seg_data),
        .dig_sel    (dig_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] sel_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst || !disp_en) k = 0;
        else k = k + 1;
        #1;
    endtask

    // First drive clock of digit d in the frame starting after base.
    task automatic push_frame(input int base, input logic [7:0] s0,
                              input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3);
        logic [7:0] s [4];
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            e.cyc = base + 8 * d + 3;
            e.sel = sel_of(d);
            e.seg = s[d];
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (seg_data !== 8'hFF) begin
            bad++;
            $display("FAIL reset_seg got=%h want=ff", seg_data);
        end
        total++;
        if (dig_sel !== 4'hF) begin
            bad++;
            $display("FAIL reset_sel got=%b want=1111", dig_sel);
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", wr_ready);
        end
        total++;
        if (commit_ack !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses got=%b%b want=00",
                     commit_ack, frame_done);
        end
        rst = 1'b0;
        tick();
        total++;
        if (dig_sel !== 4'hF || seg_data !== 8'hFF) begin
            bad++;
            $display("FAIL off_dark got=%b/%h want=1111/ff",
                     dig_sel, seg_data);
        end
    endtask

    task automatic test_enable();
        exp_t e;
        disp_en = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            e.cyc = c;
            e.sel = ((c - 1) % 8 < 2) ? 4'hF : sel_of((c - 1) / 8);
            e.seg = 8'hFF;
            sb.push_back(e);
        end
        repeat (32) begin
            tick();
            e = sb.pop_front();
            total++;
            if (k != e.cyc || dig_sel !== e.sel || seg_data !== e.seg) begin
                bad++;
                $display("FAIL enable_scan cyc=%0d got=%b/%h want=%b/%h",
                         k, dig_sel, seg_data, e.sel, e.seg);
            end
            total++;
            if (frame_done !== (k == 32)) begin
                bad++;
                $display("FAIL enable_fd cyc=%0d got=%b want=%b",
                         k, frame_done, (k == 32));
            end
        end
    endtask

    task automatic test_write_commit();
        exp_t e;
        int   x;
        for (int a = 0; a < 4; a++) begin
            total++;
            if (wr_ready !== 1'b1) begin
                bad++;
                $display("FAIL wc_ready a=%0d got=%b want=1", a, wr_ready);
            end
            wr_en = 1'b1;
            wr_addr = 2'(a);
            wr_data = 4'(a + 1);
            wr_dp = (a == 2);
            tick();
        end
        wr_en = 1'b0;
        wr_dp = 1'b0;
        commit_req = 1'b1;
        ack_q.push_back(64);
        tick();
        commit_req = 1'b0;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL wc_pending got=%b want=0", wr_ready);
        end
        wr_en = 1'b1;
        wr_addr = 2'd0;
        wr_data = 4'd9;
        wr_dp = 1'b1;
        tick();
        wr_en = 1'b0;
        wr_dp = 1'b0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (commit_ack) begin
                x = ack_q.pop_front();
                total++;
                if (k != x || frame_done !== 1'b1) begin
                    bad++;
                    $display("FAIL wc_ack got=%0d/%b want=%0d/1",
                             k, frame_done, x);
                end
                break;
            end
        end
        total++;
        if (ack_q.size() != 0) begin
            bad++;
            $display("FAIL wc_ack_timeout got=none want=ack");
            ack_q.delete();
        end
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL wc_ready_back got=%b want=1", wr_ready);
        end
        push_frame(64, 8'b10011111, 8'b00100101,
                   8'b00001100, 8'b10011001);
        repeat (31) begin
            tick();
            if (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                total++;
                if (dig_sel !== e.sel || seg_data !== e.seg) begin
                    bad++;
                    $display("FAIL wc_digit cyc=%0d got=%b/%b want=%b/%b",
                             k, dig_sel, seg_data, e.sel, e.seg);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL wc_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_lz();
        exp_t e;
        int   x;
        logic [3:0] v [4];
        v[0] = 4'd0; v[1] = 4'd5; v[2] = 4'd0; v[3] = 4'd0;
        lz_en = 1'b1;
        for (int a = 0; a < 4; a++) begin
            total++;
            if (wr_ready !== 1'b1) begin
                bad++;
                $display("FAIL lz_ready a=%0d got=%b want=1", a, wr_ready);
            end
            wr_en = 1'b1;
            wr_addr = 2'(a);
            wr_data = v[a];
            wr_dp = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        commit_req = 1'b1;
        ack_q.push_back(128);
        tick();
        commit_req = 1'b0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (commit_ack) begin
                x = ack_q.pop_front();
                total++;
                if (k != x) begin
                    bad++;
                    $display("FAIL lz_ack got=%0d want=%0d", k, x);
                end
                break;
            end
        end
        total++;
        if (ack_q.size() != 0) begin
            bad++;
            $display("FAIL lz_ack_timeout got=none want=ack");
            ack_q.delete();
        end
        push_frame(128, 8'b00000011, 8'b01001001, 8'hFF, 8'hFF);
        repeat (32) begin
            tick();
            if (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                total++;
                if (dig_sel !== e.sel || seg_data !== e.seg) begin
                    bad++;
                    $display("FAIL lz_digit cyc=%0d got=%b/%b want=%b/%b",
                             k, dig_sel, seg_data, e.sel, e.seg);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL lz_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_disable();
        exp_t e;
        for (int n = 0; n < 40; n++) begin
            if ((k - 1) % 32 == 19) break;
            tick();
        end
        total++;
        if (dig_sel !== 4'b1011) begin
            bad++;
            $display("FAIL dis_drive2 got=%b want=1011", dig_sel);
        end
        disp_en = 1'b0;
        tick();
        total++;
        if (dig_sel !== 4'hF || seg_data !== 8'hFF || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL dis_dark got=%b/%h/%b want=1111/ff/0",
                     dig_sel, seg_data, frame_done);
        end
        repeat (3) begin
            tick();
            total++;
            if (frame_done !== 1'b0 || dig_sel !== 4'hF) begin
                bad++;
                $display("FAIL dis_idle got=%b/%b want=0/1111",
                         frame_done, dig_sel);
            end
        end
        disp_en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            e.cyc = c;
            e.sel = (c >= 3 && c <= 8) ? 4'b1110 : 4'hF;
            e.seg = (c >= 3 && c <= 8) ? 8'b00000011 : 8'hFF;
            sb.push_back(e);
        end
        repeat (10) begin
            tick();
            e = sb.pop_front();
            total++;
            if (k != e.cyc || dig_sel !== e.sel || seg_data !== e.seg) begin
                bad++;
                $display("FAIL dis_restart cyc=%0d got=%b/%h want=%b/%h",
                         k, dig_sel, seg_data, e.sel, e.seg);
            end
        end
    endtask

    task automatic test_commit_off();
        disp_en = 1'b0;
        tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        total++;
        if (commit_ack !== 1'b1 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL off_ack got=%b/%b want=1/0", commit_ack, wr_ready);
        end
        tick();
        total++;
        if (commit_ack !== 1'b0 || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL off_after got=%b/%b want=0/1",
                     commit_ack, wr_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acks;
        acks = 0;
        disp_en = 1'b1;
        repeat (4) tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready got=%b want=1", wr_ready);
        end
        wr_en = 1'b1;
        wr_addr = 2'd1;
        wr_data = 4'd7;
        wr_dp = 1'b0;
        commit_req = 1'b1;
        ack_q.push_back(32);
        tick();
        wr_en = 1'b0;
        commit_req = 1'b0;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pending got=%b want=0", wr_ready);
        end
        tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        push_frame(32, 8'b00000011, 8'b00011011, 8'hFF, 8'hFF);
        repeat (57) begin
            tick();
            if (commit_ack) begin
                acks++;
                total++;
                if (ack_q.size() == 0 || k != ack_q[0]) begin
                    bad++;
                    $display("FAIL b2b_ack_cyc got=%0d want=32", k);
                end
                if (ack_q.size() > 0) ack_q.delete(0);
            end
            if (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                total++;
                if (dig_sel !== e.sel || seg_data !== e.seg) begin
                    bad++;
                    $display("FAIL b2b_digit cyc=%0d got=%b/%b want=%b/%b",
                             k, dig_sel, seg_data, e.sel, e.seg);
                end
            end
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL b2b_ack_count got=%0d want=1", acks);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_left got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_write_commit();
        test_lz();
        test_disable();
        test_commit_off();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
